// File: rtl/cfg_chain_loader.sv
// Parallel-to-serial loader for a configuration scan chain, with optional
// readback capture of the chain's previous contents (define READBACK_CAPTURE_EN).
module cfg_chain_loader #(
  parameter int CHAIN_LEN = 36,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              shift_i,
  output logic              shift_clk,
  input  logic              shift_o,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int WW = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {IDLE, FETCH, SETUP, PULSE, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WW-1:0]     wcnt_q, wcnt_d;
  logic [WORD_W-1:0] sbuf_q, sbuf_d;
  logic              shift_i_q, shift_i_d;
  logic              shift_clk_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    wcnt_d    = wcnt_q;
    sbuf_d    = sbuf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bit_cnt_d = '0;
          wcnt_d    = '0;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        if (in_valid) begin
          sbuf_d  = in_data;
          wcnt_d  = '0;
          state_d = SETUP;
        end
      end
      SETUP: state_d = PULSE;
      PULSE: begin
        sbuf_d    = sbuf_q >> 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        wcnt_d    = wcnt_q + 1'b1;
        if (bit_cnt_d == CW'(CHAIN_LEN))   state_d = DONE;
        else if (wcnt_d == WW'(WORD_W))    state_d = FETCH;
        else                               state_d = SETUP;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Data is launched on entry to SETUP so it is stable a full clk before the pulse
    shift_i_d = (state_d == SETUP) ? sbuf_d[0] : shift_i_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      wcnt_q      <= '0;
      sbuf_q      <= '0;
      shift_i_q   <= 1'b0;
      shift_clk_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      wcnt_q      <= wcnt_d;
      sbuf_q      <= sbuf_d;
      shift_i_q   <= shift_i_d;
      shift_clk_q <= (state_d == PULSE);
    end
  end

  assign shift_i   = shift_i_q;
  assign shift_clk = shift_clk_q;
  assign in_ready  = (state_q == FETCH);
  assign busy      = (state_q == FETCH) || (state_q == SETUP) || (state_q == PULSE);
  assign done      = (state_q == DONE);

`ifdef READBACK_CAPTURE_EN
  logic [WORD_W-1:0] rb_acc_q, rb_acc_d;
  logic [WORD_W-1:0] rb_data_q, rb_data_d;
  logic              rb_valid_q, rb_valid_d;

  // shift_o is sampled at the end of SETUP, before the pulse moves the chain
  always_comb begin
    rb_acc_d   = rb_acc_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    if (state_q == FETCH) begin
      rb_acc_d = '0;
    end else if (state_q == SETUP) begin
      rb_acc_d = rb_acc_q | (WORD_W'(shift_o) << wcnt_q);
      if ((wcnt_q + 1'b1 == WW'(WORD_W)) || (bit_cnt_q + 1'b1 == CW'(CHAIN_LEN))) begin
        rb_data_d  = rb_acc_d;
        rb_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_acc_q   <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_acc_q   <= rb_acc_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
`else
  logic unused_shift_o;
  assign unused_shift_o = shift_o;
  assign rb_data        = '0;
  assign rb_valid       = 1'b0;
`endif
endmodule

// File: tb/tb_cfg_chain_loader.sv
// Randomized bench for cfg_chain_loader with a behavioural 36-bit chain model.
module tb_cfg_chain_loader;
  localparam int CL = 36;
  localparam int WW = 8;
  localparam int NW = (CL + WW - 1) / WW;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [WW-1:0] in_data = '0;
  logic in_ready, shift_i, shift_clk, shift_o, busy, done, rb_valid;
  logic [WW-1:0] rb_data;
  logic [CL-1:0] chain = '0;

  int checks = 0, passes = 0;
  int rises = 0, done_cnt = 0, busy_bad = 0, rb_bad = 0;
  bit obs[$];
  longint rtimes[$];
  logic [WW-1:0] rb_q[$];
  logic [WW-1:0] words[NW];

  cfg_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .shift_i(shift_i),
    .shift_clk(shift_clk), .shift_o(shift_o), .busy(busy), .done(done),
    .rb_data(rb_data), .rb_valid(rb_valid)
  );

  always #5 clk = ~clk;

  assign shift_o = chain[CL-1];

  always @(posedge shift_clk) begin
    chain <= {chain[CL-2:0], shift_i};
    rises++;
    obs.push_back(shift_i);
    rtimes.push_back($time);
  end

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (busy !== 1'b0) busy_bad++;
    end
    if (rb_valid === 1'b1) begin
      rb_q.push_back(rb_data);
      if (shift_clk !== 1'b1) rb_bad++;
    end
`ifndef READBACK_CAPTURE_EN
    if (rb_valid !== 1'b0 || rb_data !== '0) rb_bad++;
`endif
  end

  task automatic randomize_words();
    for (int i = 0; i < NW; i++) words[i] = WW'($urandom);
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passes++;
  endtask

  task automatic run_load(input int stall_len, input bit poke, input int abort_at,
                          output bit aborted);
    int idx = 0, stall_left = 0, gap = 0, stall_bad = 0, bad = 0, period_bad = 0;
    bit seen = 0, stall_started = 0;
    logic stall_si = 1'b0;
    rises = 0; obs.delete(); rtimes.delete(); done_cnt = 0; busy_bad = 0; rb_q.delete();
    aborted = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (abort_at > 0 && rises >= abort_at) begin aborted = 1; break; end
      if (done === 1'b1) seen = 1;
      else if (busy !== 1'b1) gap++;
      if (seen) break;
      start = poke && (cyc == 20 || cyc == 21 || cyc == 50);
      in_valid = 1'b0;
      if (in_ready === 1'b1 && idx < NW) begin
        if (stall_left > 0) begin
          if (!stall_started) begin stall_started = 1; stall_si = shift_i; end
          if (shift_clk !== 1'b0 || shift_i !== stall_si) stall_bad++;
          stall_left--;
        end else begin
          in_valid = 1'b1;
          in_data  = words[idx];
          idx++;
          if (idx == 1) stall_left = stall_len;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (aborted) return;
    repeat (4) @(negedge clk);
    checks++;
    if (!seen) $display("FAIL load_timeout: done not seen within budget, expected done pulse");
    else passes++;
    chk("rise_count", rises, CL);
    for (int k = 0; k < CL; k++) begin
      if (k >= obs.size()) bad++;
      else if (obs[k] !== words[k / WW][k % WW]) bad++;
    end
    chk("bitstream_errors", bad, 0);
    chk("done_pulses", done_cnt, 1);
    chk("busy_during_done", busy_bad, 0);
    chk("busy_gap_in_load", gap, 0);
    chk("busy_after_load", busy, 0);
    if (stall_len > 0) begin
      chk("stall_cycles_seen", stall_started, 1);
      chk("stall_glitches", stall_bad, 0);
    end else begin
      for (int k = 1; k < rtimes.size(); k++)
        if (k % WW != 0 && rtimes[k] - rtimes[k-1] != 20) period_bad++;
      chk("shift_clk_period_errors", period_bad, 0);
    end
  endtask

  task automatic test_reset();
    #12;
    chk("rst_shift_clk", shift_clk, 0);
    chk("rst_shift_i", shift_i, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rb_valid", rb_valid, 0);
    chk("rst_rb_data", rb_data, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_in_ready", in_ready, 0);
  endtask

  task automatic test_pattern_a5();
    bit ab;
    randomize_words();
    words[0] = 8'hA5;
    run_load(0, 0, 0, ab);
  endtask

  task automatic test_random_loads();
    bit ab;
    for (int n = 0; n < 3; n++) begin
      randomize_words();
      run_load(0, 0, 0, ab);
    end
  endtask

  task automatic test_stall();
    bit ab;
    randomize_words();
    run_load(7, 0, 0, ab);
  endtask

  task automatic test_start_while_busy();
    bit ab;
    randomize_words();
    run_load(0, 1, 0, ab);
  endtask

  task automatic test_abort_reset();
    bit ab;
    int r;
    randomize_words();
    run_load(0, 0, 10, ab);
    chk("abort_reached", ab, 1);
    chk("abort_shift_clk_high", shift_clk, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_shift_clk", shift_clk, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_shift_i", shift_i, 0);
    r = rises;
    repeat (5) @(negedge clk);
    chk("abort_no_more_rises", rises, r);
    rst_n = 1'b1;
    @(negedge clk);
    randomize_words();
    run_load(0, 0, 0, ab);
  endtask

`ifdef READBACK_CAPTURE_EN
  task automatic test_readback();
    bit ab;
    logic [WW-1:0] p1[NW];
    logic [WW-1:0] e;
    int k;
    randomize_words();
    run_load(0, 0, 0, ab);
    for (int i = 0; i < NW; i++) p1[i] = words[i];
    randomize_words();
    run_load(0, 0, 0, ab);
    chk("rb_pulses", rb_q.size(), NW);
    for (int j = 0; j < NW && j < rb_q.size(); j++) begin
      e = '0;
      for (int b = 0; b < WW; b++) begin
        k = j * WW + b;
        if (k < CL) e[b] = p1[k / WW][k % WW];
      end
      chk($sformatf("rb_word%0d", j), rb_q[j], e);
    end
  endtask
`else
  task automatic test_readback();
    chk("rb_pulses_disabled", rb_q.size(), 0);
  endtask
`endif

  initial begin
    test_reset();
    test_pattern_a5();
    test_random_loads();
    test_stall();
    test_start_while_busy();
    test_abort_reset();
    test_readback();
    chk("rb_protocol_errors", rb_bad, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
